conv_mac_acc: RTL and testbench
===============================

Name: conv_mac_acc

Overview:
Sequential multiply-accumulate stage for the CNN convolution datapath. It streams signed 8-bit weight/activation pairs through a handshake and drives them to an external 8x8 signed multiplier instance, exact or approximate, with 16-bit output. It sign-extends each returned product and accumulates a kernel-length dot product. Because the multiplier is external, approximate variants can be swapped without touching this block.

Parameters:
ACC_W, 24, accumulator/result width in bits (must be >=17)
LEN_W, 8, width of kernel-length field; max length 2^LEN_W-1
SAT, 1, 1 = saturate on overflow, 0 = two's-complement wrap

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin new dot product (sampled only in IDLE)
len  in  LEN_W  number of operand pairs, sampled with start
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operand pair
in_a  in  8  signed activation
in_b  in  8  signed weight
mul_a  out  8  registered operand A to external multiplier
mul_b  out  8  registered operand B to external multiplier
mul_o  in  16  signed product from external multiplier (combinational from mul_a/mul_b)
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer accepts result
out_sum  out  ACC_W  signed accumulated result
out_ovf  out  1  sticky overflow flag for this dot product
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE. in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0, mul_a=mul_b=0. All pipeline valids and the counter are cleared. Reset mid-operation discards the partial sum; no result is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and len!=0: load cnt=len, clear acc and ovf, go to RUN.
  - start=1 and len=0: go directly to DONE with out_sum=0, out_ovf=0.
- RUN:
  - in_ready = (cnt!=0).
  - Accept occurs on in_valid & in_ready. On accept: mul_a<=in_a, mul_b<=in_b, s1_v<=1, cnt<=cnt-1. Otherwise s1_v<=0.
  - Stage 2: if s1_v, prod_r<=mul_o and s2_v<=1.
  - Stage 3: if s2_v, acc<=acc + sign_extend(prod_r, ACC_W).
  - RUN->DONE when cnt==0, s1_v==0, s2_v==0 and no accumulate is pending.
  - Latency: last pair accepted at edge t, out_valid=1 after edge t+3.
  - start is ignored while busy.
- Overflow: detected when the operands of an add have equal signs and the result sign differs.
  - SAT=1: acc clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1), and later adds continue from the clamped value.
  - SAT=0: acc wraps.
  - In both modes ovf is set and stays set until the next start.
- DONE: out_valid=1; out_sum and out_ovf are stable. On out_valid & out_ready go to IDLE, with out_valid=0 on the next cycle. out_sum holds its last value in IDLE.
- Back-to-back: start is accepted in the cycle after the DONE handshake (IDLE for one cycle minimum).
- in_valid with in_ready=0: no effect; the producer holds data. Bubbles in in_valid only stretch RUN.
- mul_a/mul_b keep their last values when idle, which avoids toggling the multiplier.

Decomposition:
- Package conv_mac_pkg:
  - state enum {IDLE, RUN, DONE}
  - default ACC_W/LEN_W constants
  - function sext16(prod, ACC_W)
  - function sat_add(a, b, SAT) returning {sum, ovf}
- One natural sub-module: mac_sat_add (combinational ACC_W adder with overflow detect and optional clamp), instantiated in stage 3.
- The multiplier stays outside. The bench binds any 8x8 signed multiplier to mul_a/mul_b/mul_o.

Test Plan:
- Exact multiplier, len=3, pairs (3,4),(-5,6),(127,-128) -> out_sum = 12-30-16256 = -16274, out_ovf=0, out_valid 3 cycles after the last accept.
- len=0 start -> DONE next cycle, out_sum=0, out_ovf=0, in_ready never asserted.
- ACC_W=17, SAT=1, len=5, all pairs (-128,-128)=16384 each -> clamps at 65535, out_ovf=1. Same with SAT=0 -> 81920 mod 2^17 = -49152, out_ovf=1.
- len=4 with in_valid toggled 1,0,0,1,1,0,1 and out_ready held 0 for 5 cycles -> correct sum, out_valid/out_sum stable throughout, only 4 accepts counted.
- Assert rst_n=0 mid-RUN after 2 of 4 pairs -> all outputs zero immediately (async). A following start with len=1, pair (-1,-1) gives out_sum=1.
- start pulsed during RUN/DONE -> ignored, current result unaffected. Two back-to-back dot products len=2 each -> independent sums, ovf cleared between them.

Source files
------------

// File: rtl/conv_mac_pkg.sv
// conv_mac_pkg: shared state type, default widths and accumulate helpers for conv_mac_acc
package conv_mac_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int ACC_W_DEF = 24;
    localparam int LEN_W_DEF = 8;
    localparam int MAX_W     = 64;

    typedef logic [MAX_W-1:0] wide_t;

    // Callers truncate the result to their accumulator width.
    function automatic wide_t sext16(input logic [15:0] prod);
        return wide_t'(signed'(prod));
    endfunction

    // Returns {sum, ovf} for a w-bit signed add. Only bits below w of a and b matter.
    function automatic logic [MAX_W:0] sat_add(input wide_t a, input wide_t b, input int w, input logic sat);
        wide_t s, msb, hi;
        logic  sa, sb, ss, ovf;
        s   = a + b;
        msb = wide_t'(1) << (w - 1);
        hi  = msb - wide_t'(1);
        sa  = |(a & msb);
        sb  = |(b & msb);
        ss  = |(s & msb);
        ovf = (sa == sb) && (ss != sa);
        if (ovf && sat) s = sa ? ~hi : hi;
        return {s, ovf};
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: ACC_W-bit signed adder with overflow detect and optional clamp
module mac_sat_add
    import conv_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter bit SAT   = 1'b1
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    assign sum = ACC_W'(sat_add(wide_t'(a), wide_t'(b), ACC_W, SAT) >> 1);
    assign ovf = 1'(sat_add(wide_t'(a), wide_t'(b), ACC_W, SAT));

endmodule

// File: rtl/conv_mac_acc.sv
// conv_mac_acc: streaming signed 8x8 multiply-accumulate with an external multiplier
module conv_mac_acc
    import conv_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic               s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [15:0]        prod_q, prod_d;
    logic [ACC_W-1:0]   acc_q, acc_d, prod_ext, add_sum;
    logic               ovf_q, ovf_d, add_ovf, accept;

    assign in_ready  = (state_q == RUN) && (cnt_q != '0);
    assign accept    = in_ready && in_valid;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign prod_ext  = ACC_W'(sext16(prod_q));

    mac_sat_add #(.ACC_W(ACC_W), .SAT(SAT != 0)) u_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Operand capture, product and accumulate pipeline plus the IDLE/RUN/DONE sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = accept ? cnt_q - 1'b1 : cnt_q;
        mul_a_d = accept ? in_a : mul_a_q;
        mul_b_d = accept ? in_b : mul_b_q;
        s1_v_d  = accept;
        s2_v_d  = s1_v_q;
        prod_d  = s1_v_q ? mul_o : prod_q;
        acc_d   = s2_v_q ? add_sum : acc_q;
        ovf_d   = ovf_q | (s2_v_q & add_ovf);
        case (state_q)
            IDLE: if (start) begin
                cnt_d   = len;
                acc_d   = '0;
                ovf_d   = 1'b0;
                state_d = (len != '0) ? RUN : DONE;
            end
            RUN:     state_d = (cnt_q == '0 && !s1_v_q && !s2_v_q) ? DONE : RUN;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
            prod_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            s1_v_q  <= s1_v_d;
            s2_v_q  <= s2_v_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_conv_mac_acc.sv
// tb_conv_mac_acc: scoreboard bench driving 24-bit saturating and 17-bit saturating/wrapping instances
module tb_conv_mac_acc;

    typedef struct {
        longint s0; bit o0;
        longint s1; bit o1;
        longint s2; bit o2;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]  len = '0, in_a = '0, in_b = '0;
    logic        ir0, ov0, of0, bz0, ir1, ov1, of1, bz1, ir2, ov2, of2, bz2;
    logic [7:0]  ma0, mb0, ma1, mb1, ma2, mb2;
    logic [15:0] mo0, mo1, mo2;
    logic [23:0] sum0;
    logic [16:0] sum1, sum2;

    logic signed [7:0] pa [0:7];
    logic signed [7:0] pb [0:7];
    exp_t q[$];
    exp_t mon_e;
    int vectors = 0, miscompares = 0, accepts = 0;

    always #5 clk = ~clk;

    assign mo0 = $signed({{8{ma0[7]}}, ma0}) * $signed({{8{mb0[7]}}, mb0});
    assign mo1 = $signed({{8{ma1[7]}}, ma1}) * $signed({{8{mb1[7]}}, mb1});
    assign mo2 = $signed({{8{ma2[7]}}, ma2}) * $signed({{8{mb2[7]}}, mb2});

    conv_mac_acc #(.ACC_W(24), .LEN_W(8), .SAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .in_ready(ir0),
        .in_a(in_a), .in_b(in_b), .mul_a(ma0), .mul_b(mb0), .mul_o(mo0), .out_valid(ov0),
        .out_ready(out_ready), .out_sum(sum0), .out_ovf(of0), .busy(bz0));

    conv_mac_acc #(.ACC_W(17), .LEN_W(8), .SAT(1)) u_sat17 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .in_ready(ir1),
        .in_a(in_a), .in_b(in_b), .mul_a(ma1), .mul_b(mb1), .mul_o(mo1), .out_valid(ov1),
        .out_ready(out_ready), .out_sum(sum1), .out_ovf(of1), .busy(bz1));

    conv_mac_acc #(.ACC_W(17), .LEN_W(8), .SAT(0)) u_wrap17 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .in_ready(ir2),
        .in_a(in_a), .in_b(in_b), .mul_a(ma2), .mul_b(mb2), .mul_o(mo2), .out_valid(ov2),
        .out_ready(out_ready), .out_sum(sum2), .out_ovf(of2), .busy(bz2));

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input int i, input int a, input int b);
        pa[i] = 8'(a);
        pb[i] = 8'(b);
    endtask

    function automatic void model(input int n, input int w, input bit sat, output longint s, output bit o);
        longint m, hi, lo;
        m  = longint'(1) << w;
        hi = m / 2 - 1;
        lo = -(m / 2);
        s  = 0;
        o  = 1'b0;
        for (int i = 0; i < n; i++) begin
            s += longint'(pa[i]) * longint'(pb[i]);
            if (s > hi) begin
                o = 1'b1;
                s = sat ? hi : s - m;
            end else if (s < lo) begin
                o = 1'b1;
                s = sat ? lo : s + m;
            end
        end
    endfunction

    // Count accepted pairs and score every result handshake against the queue
    always @(negedge clk) begin
        if (ir0 && in_valid) accepts++;
        if (ov0 && out_ready) begin
            if (q.size() == 0) check("unexpected_result", 1, 0);
            else begin
                mon_e = q.pop_front();
                check("sum24", $signed(sum0), mon_e.s0);
                check("ovf24", of0, mon_e.o0);
                check("sum17_sat", $signed(sum1), mon_e.s1);
                check("ovf17_sat", of1, mon_e.o1);
                check("sum17_wrap", $signed(sum2), mon_e.s2);
                check("ovf17_wrap", of2, mon_e.o2);
                check("valid17", {ov1, ov2}, 2'b11);
            end
        end
    end

    task automatic run(input int n, input logic [15:0] vpat, input int hold, input bit poke);
        exp_t e;
        int   k, step, a0;
        bit   took;
        model(n, 24, 1'b1, e.s0, e.o0);
        model(n, 17, 1'b1, e.s1, e.o1);
        model(n, 17, 1'b0, e.s2, e.o2);
        q.push_back(e);
        a0 = accepts;
        start = 1'b1;
        len   = 8'(n);
        tick;
        start = 1'b0;
        if (n == 0) check("len0_ready", ir0, 0);
        k    = 0;
        step = 0;
        while (k < n && step < 200) begin
            in_valid = vpat[step % 16];
            in_a     = pa[k];
            in_b     = pb[k];
            if (poke && step == 1) begin
                start = 1'b1;
                len   = 8'd7;
            end
            @(negedge clk);
            took = in_valid && ir0;
            tick;
            start = 1'b0;
            if (took) k++;
            step++;
        end
        in_valid = 1'b0;
        if (k < n) check("feed_timeout", k, n);
        if (n > 0) begin
            for (int c = 1; c <= 3; c++) begin
                tick;
                check("latency", ov0, c == 3);
            end
        end else check("len0_valid", ov0, 1);
        check("accept_count", accepts - a0, n);
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                start = 1'b1;
                len   = 8'd3;
            end
            check("hold_valid", ov0, 1);
            check("hold_sum", $signed(sum0), e.s0);
            check("hold_ovf17", of1, e.o1);
            tick;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("idle_valid", ov0, 0);
        check("idle_busy", bz0, 0);
        check("idle_sum", $signed(sum0), e.s0);
    endtask

    initial begin
        #1;
        check("rst_valid", ov0, 0);
        check("rst_ready", ir0, 0);
        check("rst_busy", bz0, 0);
        check("rst_sum", sum0, 0);
        check("rst_ovf", of0, 0);
        check("rst_mul", {ma0, mb0}, 0);
        #12;
        @(negedge clk) rst_n = 1'b1;
        tick;

        set_pair(0, 3, 4); set_pair(1, -5, 6); set_pair(2, 127, -128);
        run(3, 16'hFFFF, 0, 1'b0);

        run(0, 16'hFFFF, 0, 1'b0);

        for (int i = 0; i < 5; i++) set_pair(i, -128, -128);
        run(5, 16'hFFFF, 2, 1'b0);

        set_pair(0, 2, 9); set_pair(1, -3, 4);
        run(2, 16'hFFFF, 2, 1'b1);
        set_pair(0, -7, 11); set_pair(1, 100, -2);
        run(2, 16'hFFFF, 0, 1'b0);

        set_pair(0, -100, 90); set_pair(1, 50, -60); set_pair(2, 77, 33); set_pair(3, -1, 127);
        run(4, 16'h0059, 5, 1'b0);

        start = 1'b1;
        len   = 8'd4;
        tick;
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = 8'd5;
        in_b     = 8'd7;
        tick;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        check("pre_rst_busy", bz0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", ov0, 0);
        check("arst_ready", ir0, 0);
        check("arst_busy", bz0, 0);
        check("arst_sum", sum0, 0);
        check("arst_ovf", of0, 0);
        check("arst_mul", {ma0, mb0}, 0);
        @(negedge clk) rst_n = 1'b1;
        tick;
        set_pair(0, -1, -1);
        run(1, 16'hFFFF, 0, 1'b0);

        tick;
        check("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
